// File: rtl/tlb_pkg.sv
// Shared TLB definitions: header field layout, default widths and the
// write/flush sequencer state encoding.
package tlb_pkg;

   localparam int unsigned TLB_HALF_W = 25;  // {PFN, C, D, V, G}
   localparam int unsigned TLB_HDR_W  = 44;  // {PageMask, EntryHi, G}

   localparam int unsigned TLB_G_OFF   = 0;
   localparam int unsigned TLB_EHI_OFF = 1;
   localparam int unsigned TLB_EHI_W   = 27;
   localparam int unsigned TLB_PM_OFF  = TLB_EHI_OFF + TLB_EHI_W;
   localparam int unsigned TLB_PM_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR2   = 2'd1,
      ST_SWEEP = 2'd2
   } tlb_state_e;

endpackage

// File: rtl/tlb_wr_ctrl.sv
// Write/flush sequencer for tlb_entry_array: two-cycle entry write (even half,
// then staged odd half) and the one-entry-per-cycle valid-bit sweep.
import tlb_pkg::*;

module tlb_wr_ctrl #(
   parameter  int unsigned ENTRIES = 32,
   parameter  int unsigned HALF_W  = TLB_HALF_W,
   localparam int unsigned IW      = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic [IW-1:0]     wr_idx,
   input  logic [HALF_W-1:0] wr_odd,
   input  logic              flush_req,
   output logic              wr_ready,
   output logic              wr_accept,
   output logic              odd_we,
   output logic [IW-1:0]     odd_idx,
   output logic [HALF_W-1:0] odd_data,
   output logic              sweep_clr,
   output logic [IW-1:0]     sweep_idx,
   output logic              flush_busy,
   output logic              flush_done
);

   localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

   tlb_state_e        state_q, state_d;
   logic [IW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     odd_idx_q, odd_idx_d;
   logic [HALF_W-1:0] odd_data_q, odd_data_d;
   logic              wr_ready_q, wr_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      odd_idx_d  = odd_idx_q;
      odd_data_d = odd_data_q;
      wr_ready_d = wr_ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A write takes priority; a held flush_req starts on the next IDLE cycle.
            if (wr_req) begin
               state_d    = ST_WR2;
               odd_idx_d  = wr_idx;
               odd_data_d = wr_odd;
               wr_ready_d = 1'b0;
            end else if (flush_req) begin
               state_d    = ST_SWEEP;
               cnt_d      = '0;
               wr_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_WR2: begin
            state_d    = ST_IDLE;
            wr_ready_d = 1'b1;
         end
         ST_SWEEP: begin
            cnt_d = cnt_q + IW'(1);
            // done is registered, so it is raised while entering the last count
            if (cnt_q == LAST - IW'(1)) done_d = 1'b1;
            if (cnt_q == LAST) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               wr_ready_d = 1'b1;
               busy_d     = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            wr_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         odd_idx_q  <= '0;
         odd_data_q <= '0;
         wr_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         odd_idx_q  <= odd_idx_d;
         odd_data_q <= odd_data_d;
         wr_ready_q <= wr_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign wr_ready   = wr_ready_q;
   assign wr_accept  = wr_ready_q & wr_req;
   assign odd_we     = (state_q == ST_WR2);
   assign odd_idx    = odd_idx_q;
   assign odd_data   = odd_data_q;
   assign sweep_clr  = (state_q == ST_SWEEP);
   assign sweep_idx  = cnt_q;
   assign flush_busy = busy_q;
   assign flush_done = done_q;

endmodule

// File: rtl/tlb_entry_array.sv
// TLB entry storage with two half-entry lookup ports, a TLBR read port and a
// sequenced write/flush path. Define TLB_LOOKUP_REG_EN to register ports A/B.
import tlb_pkg::*;

module tlb_entry_array #(
   parameter  int unsigned ENTRIES = 32,
   parameter  int unsigned HALF_W  = TLB_HALF_W,
   parameter  int unsigned HDR_W   = TLB_HDR_W,
   localparam int unsigned IW      = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IW:0]         idx_a,
   output logic [HALF_W-1:0]   entry_a,
   output logic [15:0]         pmask_a,
   output logic                valid_a,
   input  logic [IW:0]         idx_b,
   output logic [HALF_W-1:0]   entry_b,
   output logic [15:0]         pmask_b,
   output logic                valid_b,
   input  logic [IW-1:0]       idx_c,
   output logic [2*HALF_W-1:0] entry_c,
   output logic [HDR_W-1:0]    header_c,
   output logic                valid_c,
   input  logic                wr_req,
   input  logic [IW-1:0]       wr_idx,
   input  logic [2*HALF_W-1:0] wr_entry,
   input  logic [HDR_W-1:0]    wr_header,
   output logic                wr_ready,
   input  logic                flush_req,
   output logic                flush_busy,
   output logic                flush_done
);

   logic [HALF_W-1:0]  half_q [2*ENTRIES];
   logic [HDR_W-1:0]   hdr_q  [ENTRIES];
   logic [ENTRIES-1:0] valid_q, valid_d;

   logic              wr_accept, odd_we, sweep_clr;
   logic [IW-1:0]     odd_idx, sweep_idx;
   logic [HALF_W-1:0] odd_data;
   logic              half_we;
   logic [IW:0]       half_addr;
   logic [HALF_W-1:0] half_data;

   tlb_wr_ctrl #(
      .ENTRIES (ENTRIES),
      .HALF_W  (HALF_W)
   ) u_wr_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_req     (wr_req),
      .wr_idx     (wr_idx),
      .wr_odd     (wr_entry[2*HALF_W-1:HALF_W]),
      .flush_req  (flush_req),
      .wr_ready   (wr_ready),
      .wr_accept  (wr_accept),
      .odd_we     (odd_we),
      .odd_idx    (odd_idx),
      .odd_data   (odd_data),
      .sweep_clr  (sweep_clr),
      .sweep_idx  (sweep_idx),
      .flush_busy (flush_busy),
      .flush_done (flush_done)
   );

   // Even and odd writes never coincide (IDLE vs WR2), so one half-array port suffices.
   always_comb begin
      half_we   = wr_accept | odd_we;
      half_addr = wr_accept ? {wr_idx, 1'b0} : {odd_idx, 1'b1};
      half_data = wr_accept ? wr_entry[HALF_W-1:0] : odd_data;
   end

   always_ff @(posedge clk) begin
      if (half_we)   half_q[half_addr] <= half_data;
      if (wr_accept) hdr_q[wr_idx]     <= wr_header;
   end

   always_comb begin
      valid_d = valid_q;
      if (wr_accept) valid_d[wr_idx]    = 1'b1;
      if (sweep_clr) valid_d[sweep_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   logic [HALF_W-1:0] entry_a_d, entry_b_d;
   logic [15:0]       pmask_a_d, pmask_b_d;
   logic              valid_a_d, valid_b_d;

   always_comb begin
      entry_a_d = half_q[idx_a];
      pmask_a_d = hdr_q[idx_a[IW:1]][TLB_PM_OFF +: TLB_PM_W];
      valid_a_d = valid_q[idx_a[IW:1]];
      entry_b_d = half_q[idx_b];
      pmask_b_d = hdr_q[idx_b[IW:1]][TLB_PM_OFF +: TLB_PM_W];
      valid_b_d = valid_q[idx_b[IW:1]];
   end

`ifdef TLB_LOOKUP_REG_EN
   logic [HALF_W-1:0] entry_a_q, entry_b_q;
   logic [15:0]       pmask_a_q, pmask_b_q;
   logic              valid_a_q, valid_b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_a_q <= '0;
         pmask_a_q <= '0;
         valid_a_q <= 1'b0;
         entry_b_q <= '0;
         pmask_b_q <= '0;
         valid_b_q <= 1'b0;
      end else begin
         entry_a_q <= entry_a_d;
         pmask_a_q <= pmask_a_d;
         valid_a_q <= valid_a_d;
         entry_b_q <= entry_b_d;
         pmask_b_q <= pmask_b_d;
         valid_b_q <= valid_b_d;
      end
   end

   assign entry_a = entry_a_q;
   assign pmask_a = pmask_a_q;
   assign valid_a = valid_a_q;
   assign entry_b = entry_b_q;
   assign pmask_b = pmask_b_q;
   assign valid_b = valid_b_q;
`else
   assign entry_a = entry_a_d;
   assign pmask_a = pmask_a_d;
   assign valid_a = valid_a_d;
   assign entry_b = entry_b_d;
   assign pmask_b = pmask_b_d;
   assign valid_b = valid_b_d;
`endif

   assign entry_c  = {half_q[{idx_c, 1'b1}], half_q[{idx_c, 1'b0}]};
   assign header_c = hdr_q[idx_c];
   assign valid_c  = valid_q[idx_c];

endmodule

// File: tb/tb_tlb_entry_array.sv
// Bench for tlb_entry_array: directed scenarios plus random traffic against a
// transaction-level model. Follows TLB_LOOKUP_REG_EN for lookup latency.
module tb_tlb_entry_array;

   localparam int unsigned E   = 32;
   localparam int unsigned IW  = 5;
   localparam int unsigned HW  = 25;
   localparam int unsigned HDW = 44;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [IW:0]     idx_a = '0, idx_b = '0;
   logic [IW-1:0]   idx_c = '0;
   logic [HW-1:0]   entry_a, entry_b;
   logic [15:0]     pmask_a, pmask_b;
   logic            valid_a, valid_b, valid_c;
   logic [2*HW-1:0] entry_c;
   logic [HDW-1:0]  header_c;
   logic            wr_req = 1'b0;
   logic [IW-1:0]   wr_idx = '0;
   logic [2*HW-1:0] wr_entry = '0;
   logic [HDW-1:0]  wr_header = '0;
   logic            wr_ready, flush_req = 1'b0, flush_busy, flush_done;

   tlb_entry_array #(.ENTRIES(E), .HALF_W(HW), .HDR_W(HDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .idx_a(idx_a), .entry_a(entry_a), .pmask_a(pmask_a), .valid_a(valid_a),
      .idx_b(idx_b), .entry_b(entry_b), .pmask_b(pmask_b), .valid_b(valid_b),
      .idx_c(idx_c), .entry_c(entry_c), .header_c(header_c), .valid_c(valid_c),
      .wr_req(wr_req), .wr_idx(wr_idx), .wr_entry(wr_entry), .wr_header(wr_header),
      .wr_ready(wr_ready), .flush_req(flush_req), .flush_busy(flush_busy),
      .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   // Reference model: storage contents, valid bits and the pending operation.
   logic [HW-1:0]  m_half [2*E];
   logic [HDW-1:0] m_hdr  [E];
   logic [E-1:0]   m_valid;
   bit             m_pend, m_sweep;
   int unsigned    m_pidx, m_cnt;
   logic [HW-1:0]  m_podd;
   logic [HW-1:0]  ra_e, rb_e;
   logic [15:0]    ra_p, rb_p;
   logic           ra_v, rb_v;
   bit             init_done = 0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic logic [15:0] pm(input logic [HDW-1:0] h);
      return h[43:28];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = '0;
      m_pend  = 0;
      m_sweep = 0;
      m_cnt   = 0;
      ra_e = '0; ra_p = '0; ra_v = 1'b0;
      rb_e = '0; rb_p = '0; rb_v = 1'b0;
   endtask

   task automatic model_edge();
      ra_e = m_half[idx_a]; ra_p = pm(m_hdr[idx_a[IW:1]]); ra_v = m_valid[idx_a[IW:1]];
      rb_e = m_half[idx_b]; rb_p = pm(m_hdr[idx_b[IW:1]]); rb_v = m_valid[idx_b[IW:1]];
      if (m_sweep) begin
         m_valid[m_cnt] = 1'b0;
         if (m_cnt == E - 1) m_sweep = 0;
         else m_cnt++;
      end else if (m_pend) begin
         m_half[2*m_pidx+1] = m_podd;
         m_pend = 0;
      end else if (wr_req) begin
         m_hdr[wr_idx]        = wr_header;
         m_half[2*wr_idx]     = wr_entry[HW-1:0];
         m_valid[wr_idx]      = 1'b1;
         m_podd               = wr_entry[2*HW-1:HW];
         m_pidx               = wr_idx;
         m_pend               = 1;
      end else if (flush_req) begin
         m_sweep = 1;
         m_cnt   = 0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [HW-1:0] ea, eb;
      logic [15:0]   pa, pb;
      logic          va, vb;
`ifdef TLB_LOOKUP_REG_EN
      ea = ra_e; pa = ra_p; va = ra_v;
      eb = rb_e; pb = rb_p; vb = rb_v;
`else
      ea = m_half[idx_a]; pa = pm(m_hdr[idx_a[IW:1]]); va = m_valid[idx_a[IW:1]];
      eb = m_half[idx_b]; pb = pm(m_hdr[idx_b[IW:1]]); vb = m_valid[idx_b[IW:1]];
`endif
      chk({tag, ".wr_ready"},   wr_ready,   !m_sweep && !m_pend);
      chk({tag, ".flush_busy"}, flush_busy, m_sweep);
      chk({tag, ".flush_done"}, flush_done, m_sweep && m_cnt == E - 1);
      chk({tag, ".valid_a"},    valid_a,    va);
      chk({tag, ".valid_b"},    valid_b,    vb);
      chk({tag, ".valid_c"},    valid_c,    m_valid[idx_c]);
      if (init_done) begin
         chk({tag, ".entry_a"},  entry_a,  ea);
         chk({tag, ".pmask_a"},  pmask_a,  pa);
         chk({tag, ".entry_b"},  entry_b,  eb);
         chk({tag, ".pmask_b"},  pmask_b,  pb);
         chk({tag, ".entry_c"},  entry_c,  {m_half[2*idx_c+1], m_half[2*idx_c]});
         chk({tag, ".header_c"}, header_c, m_hdr[idx_c]);
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all("reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic write(input logic [IW-1:0] idx, input logic [2*HW-1:0] ent,
                        input logic [HDW-1:0] hdr, input string tag);
      wr_req = 1'b1; wr_idx = idx; wr_entry = ent; wr_header = hdr;
      step(tag);
      wr_req = 1'b0;
   endtask

   int unsigned busy_cnt, done_cnt;
   logic [HW-1:0] old_odd;

   initial begin
      model_reset();
      @(negedge clk);
      check_all("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      check_all("post_reset");

      for (int unsigned e = 0; e < E; e++) begin
         write(IW'(e), 50'({$urandom(), $urandom()}), 44'({$urandom(), $urandom()}), "init_wr");
         step("init_wr2");
      end
      step("init_idle");
      init_done = 1;

      // Write idx 3 and read both halves back through port A.
      write(5'd3, {25'h0ABCDEF, 25'h1234567}, {16'h0003, 27'h5A5A5A5, 1'b0}, "w3");
      #1 chk("w3_ready_low", wr_ready, 1'b0);
      step("w3_wr2");
      idx_a = 6'd6; step("rd6"); step("rd6b");
      #1 chk("w3_even", entry_a, 25'h1234567);
      chk("w3_pmask", pmask_a, 16'h0003);
      chk("w3_valid", valid_a, 1'b1);
      idx_a = 6'd7; step("rd7"); step("rd7b");
      #1 chk("w3_odd", entry_a, 25'h0ABCDEF);

      // Write idx 5; odd half (half index 11) is stale for one cycle.
      idx_b = 6'd11;
      old_odd = m_half[11];
      write(5'd5, {25'h1111111, 25'h0222222}, 44'h0000FFFF_ABC, "w5");
`ifndef TLB_LOOKUP_REG_EN
      #1 chk("w5_stale", entry_b, old_odd);
`endif
      step("w5_t1");
      step("w5_t2");
      #1 chk("w5_new", entry_b, 25'h1111111);

      // Flush after writing entries 0 and 31.
      write(5'd0, 50'h1, 44'h1, "w0"); step("w0_wr2");
      write(5'd31, 50'h2, 44'h2, "w31"); step("w31_wr2");
      flush_req = 1'b1; busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (flush_busy) begin busy_cnt++; flush_req = 1'b0; end
         if (flush_done) done_cnt++;
         step("flush");
      end
      flush_req = 1'b0;
      chk("flush_busy_cycles", busy_cnt, 32);
      chk("flush_done_pulses", done_cnt, 1);
      for (int unsigned c = 0; c < E; c++) begin
         idx_c = IW'(c);
         #1 chk("valid_c_after_flush", valid_c, 1'b0);
         step("flush_scan");
      end

      // Simultaneous write and flush request: write first, then the sweep.
      idx_c = 5'd9;
      flush_req = 1'b1;
      write(5'd9, 50'h3_0000_0000_0009, 44'h9, "wf");
      step("wf_wr2");
      #1 chk("wf_not_busy_yet", flush_busy, 1'b0);
      for (int i = 0; i < 36; i++) begin
         #1 if (flush_busy) flush_req = 1'b0;
         step("wf_sweep");
      end
      #1 chk("wf_entry_invalid", valid_c, 1'b0);

      // Reset in the middle of a sweep at counter 10.
      write(5'd20, 50'h5, 44'h5, "w20"); step("w20_wr2");
      flush_req = 1'b1; step("sw_start"); flush_req = 1'b0;
      for (int i = 0; i < 10; i++) step("sw_run");
      apply_reset();
      #1 chk("rst_ready", wr_ready, 1'b1);
      chk("rst_busy", flush_busy, 1'b0);
      for (int unsigned c = 0; c < E; c++) begin
         idx_c = IW'(c);
         #1 chk("rst_valid_c", valid_c, 1'b0);
         step("rst_scan");
      end

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         wr_req    = ($urandom_range(0, 3) == 0);
         flush_req = ($urandom_range(0, 40) == 0);
         wr_idx    = IW'($urandom());
         wr_entry  = 50'({$urandom(), $urandom()});
         wr_header = 44'({$urandom(), $urandom()});
         idx_a     = (IW+1)'($urandom());
         idx_b     = ($urandom_range(0, 3) == 0) ? idx_a : (IW+1)'($urandom());
         idx_c     = ($urandom_range(0, 3) == 0) ? idx_a[IW:1] : IW'($urandom());
         step("rand");
      end
      wr_req = 1'b0; flush_req = 1'b0;
      for (int i = 0; i < 36; i++) step("drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tlb_entry_array.md
TLB_ENTRY_ARRAY -- requirements
Module: tlb_entry_array

Interface
REQ-001 Parameter ENTRIES, default 32, meaning TLB entry pairs; power of 2, 16..64; IW = log2(ENTRIES).
REQ-002 Parameter HALF_W, default 25, meaning width of one EntryLo half {PFN, C, D, V, G}.
REQ-003 Parameter HDR_W, default 44, meaning header width {PageMask, EntryHi, G}; PageMask field position comes from the shared package.
REQ-004 Port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-006 Ports idx_a/idx_b, input, IW+1, meaning half-entry lookup index; bit 0 selects even/odd, bits [IW:1] select the entry.
REQ-007 Ports entry_a/entry_b, output, HALF_W, meaning the selected half-entry.
REQ-008 Ports pmask_a/pmask_b, output, 16, meaning the PageMask of entry idx[IW:1].
REQ-009 Ports valid_a/valid_b, output, 1, meaning the entry-valid bit of entry idx[IW:1].
REQ-010 Port idx_c, input, IW, meaning the TLBR index.
REQ-011 Port entry_c, output, 2*HALF_W, meaning {odd, even} halves of the entry at idx_c.
REQ-012 Port header_c, output, HDR_W, meaning the header of the entry at idx_c.
REQ-013 Port valid_c, output, 1, meaning the valid bit of the entry at idx_c.
REQ-014 Write inputs, each meaning TLBWI/TLBWR data: wr_req (input, 1), wr_idx (input, IW), wr_entry (input, 2*HALF_W), wr_header (input, HDR_W).
REQ-015 Port wr_ready, output, 1, meaning a write is accepted when wr_req && wr_ready.
REQ-016 Port flush_req, input, 1, meaning invalidate-all request; level, held until flush_busy rises.
REQ-017 Port flush_busy, output, 1, meaning a sweep is in progress.
REQ-018 Port flush_done, output, 1, meaning a one-cycle pulse on the last sweep cycle.

Function
REQ-019 The block SHALL implement FSM states IDLE, WR2 and SWEEP.
REQ-020 In IDLE, wr_ready SHALL be 1; in WR2 and SWEEP it SHALL be 0.
REQ-021 On an accepted write at edge T, the block SHALL write header, PageMask and the even half (wr_entry[HALF_W-1:0]), set valid[wr_idx], register the odd half and wr_idx, and go to WR2.
REQ-022 In WR2 at edge T+1, the block SHALL write the registered odd half to half-index {wr_idx,1} and return to IDLE.
REQ-023 A lookup of the odd half in cycle T+1 SHALL return the old data; this one-cycle staleness is specified behaviour.
REQ-024 In IDLE with flush_req && !wr_req, the block SHALL enter SWEEP with counter = 0.
REQ-025 If wr_req and flush_req are both set in IDLE, the write SHALL win and the flush SHALL start in the next IDLE cycle.
REQ-026 In SWEEP, each cycle SHALL clear valid[counter] and increment the counter.
REQ-027 At counter = ENTRIES-1, the block SHALL pulse flush_done and return to IDLE; the sweep lasts exactly ENTRIES cycles, with no wrap beyond that.
REQ-028 flush_busy SHALL be 1 exactly while in SWEEP.
REQ-029 Lookup ports A and B and read port C SHALL be mutually independent and may address the same entry simultaneously.
REQ-030 A same-cycle read and write SHALL return the pre-write data.

Reset
REQ-031 Asserting rst_n low SHALL asynchronously clear all valid bits and set state to IDLE, counter to 0, flush_done to 0 and flush_busy to 0.
REQ-032 Reset SHALL force wr_ready to 1 from the first cycle after release.
REQ-033 The storage arrays SHALL NOT be reset; their contents are qualified only by the valid bits.
REQ-034 Reset during WR2 or SWEEP SHALL abort the operation; the odd half is not written, and all valid bits are clear.

Configuration
REQ-035 With macro TLB_LOOKUP_REG_EN defined, entry_a/b, pmask_a/b and valid_a/b SHALL be registered, with 1-cycle latency from idx and a reset value of 0.
REQ-036 With TLB_LOOKUP_REG_EN undefined, those outputs SHALL be combinational from idx_a/idx_b with 0-cycle latency.
REQ-037 Port C SHALL be combinational in both builds.

Structure
REQ-038 Package tlb_pkg SHALL hold the PageMask/EntryHi/G field offsets within the header, the default HALF_W/HDR_W values and the state encoding.
REQ-039 The FSM, sweep counter and odd-half staging registers SHALL live in a single sub-module, tlb_wr_ctrl; the storage SHALL stay in the top level.

Verification
REQ-040 Scenario: write idx 3, entry {odd=0x0ABCDEF, even=0x1234567}, PageMask 0x0003 -> wr_ready=0 for one cycle; afterwards idx_a=6 gives 0x1234567, idx_a=7 gives 0x0ABCDEF, pmask_a=0x0003 and valid_a=1.
REQ-041 Scenario: write idx 5, then lookup idx_b=11 in cycle T+1 and again at T+2 -> the old value at T+1, the new value at T+2.
REQ-042 Scenario: write entries 0 and 31, then flush_req -> flush_busy=1 for 32 cycles, flush_done pulses once on the last cycle, and afterwards valid_c=0 for every idx_c.
REQ-043 Scenario: wr_req and flush_req in the same IDLE cycle -> write completes (2 cycles), the sweep starts in the next cycle, and the entry ends invalid.
REQ-044 Scenario: rst_n low mid-sweep at counter 10 -> state IDLE, flush_busy=0, all valid bits 0 and wr_ready=1 after release.
REQ-045 Scenario: run REQ-040 with TLB_LOOKUP_REG_EN defined -> entry_a is updated one cycle after idx_a changes, and is 0 after reset.
